// File: rtl/lru_pkg.sv
// Shared definitions for the LRU command arbiter.
// op_t         : request opcode carried from the requesters to the LRU block.
// Err*         : bit positions in the protocol-error cause vector; any set cause latches err_o.
package lru_pkg;

  typedef enum logic [1:0] {
    OpNop   = 2'b00,
    OpLoad  = 2'b01,
    OpStore = 2'b10,
    OpInv   = 2'b11
  } op_t;

  // lru_valid_i seen without an issued STORE
  localparam int unsigned ErrSpurious  = 0;
  // issued STORE received no allocation
  localparam int unsigned ErrMissing   = 1;
  // allocation way vector not one-hot
  localparam int unsigned ErrNotOneHot = 2;
  localparam int unsigned NumErrCauses = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first requester at or after ptr_i, wrapping modulo N.
// Ports:
//   req_i  N-bit request vector
//   ptr_i  index of the highest-priority requester (must be < N)
//   gnt_o  one-hot grant, all zero when no request
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = $clog2(N),
  localparam int unsigned IdxW = PtrW + 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr_i < N and i < N, so a single subtraction wraps the sum
      idx = {1'b0, ptr_i} + IdxW'(i);
      if (idx >= IdxW'(N)) begin
        idx = idx - IdxW'(N);
      end
      if (!found && req_i[idx[PtrW-1:0]]) begin
        gnt_o[idx[PtrW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lru_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single registered command port toward an LRU block
// and routes STORE allocation results back to the owning requester one cycle later.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid_i/op_i/way_i  per-requester request; req_ready_o is the one-hot accept
//   ls_valid_o/op_o/way_o   registered command (NOPs are consumed and never issued)
//   lru_valid_i/way_i       one-hot allocation from the LRU, same cycle as an issued STORE
//   rsp_valid_o/way_o       one-cycle allocation response to the STORE owner
//   err_o                   sticky protocol error
// Optional feature: define LRU_ARB_INV_PRIO_EN to let any valid INVALIDATE win over
// LOAD/STORE; the round-robin pointer is shared between both classes.
module lru_arbiter
  import lru_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned PtrW = $clog2(NUM_REQ),
  localparam int unsigned WayW = $clog2(NUM_WAYS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0][1:0]       req_op_i,
  input  logic [NUM_REQ-1:0][WayW-1:0]  req_way_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          ls_valid_o,
  output logic [1:0]                    ls_op_o,
  output logic [WayW-1:0]               ls_way_o,
  input  logic                          lru_valid_i,
  input  logic [NUM_WAYS-1:0]           lru_way_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WayW-1:0]               rsp_way_o,
  output logic                          err_o
);

  logic [NUM_REQ-1:0] arb_req, gnt;
  logic [PtrW-1:0]    ptr_q, ptr_d, gnt_idx;
  logic               accept;
  op_t                sel_op;

  logic               ls_valid_q, ls_valid_d;
  op_t                ls_op_q, ls_op_d;
  logic [WayW-1:0]    ls_way_q, ls_way_d;
  logic [PtrW-1:0]    owner_q, owner_d;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WayW-1:0]    rsp_way_q, rsp_way_d, lru_way_enc;
  logic               err_q, err_d;

  logic [NumErrCauses-1:0] err_cause;
  logic                    store_issued, way_onehot, rsp_fire;

`ifdef LRU_ARB_INV_PRIO_EN
  logic [NUM_REQ-1:0] inv_req;

  always_comb begin
    inv_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inv_req[i] = req_valid_i[i] && (op_t'(req_op_i[i]) == OpInv);
    end
    // Only INVALIDATEs compete while any is pending
    arb_req = (|inv_req) ? inv_req : req_valid_i;
  end
`else
  assign arb_req = req_valid_i;
`endif

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign req_ready_o = reset ? '0 : gnt;
  assign accept      = |req_ready_o;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PtrW'(i);
      end
    end
  end

  assign sel_op = op_t'(req_op_i[gnt_idx]);

  // Request stage: pointer and command register
  always_comb begin
    ptr_d      = ptr_q;
    ls_valid_d = 1'b0;
    ls_op_d    = ls_op_q;
    ls_way_d   = ls_way_q;
    owner_d    = owner_q;
    if (accept) begin
      ptr_d = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
      if (sel_op != OpNop) begin
        ls_valid_d = 1'b1;
        ls_op_d    = sel_op;
        ls_way_d   = req_way_i[gnt_idx];
        owner_d    = gnt_idx;
      end
    end
  end

  // Response stage: check the LRU handshake against the issued command
  assign store_issued = ls_valid_q && (ls_op_q == OpStore);
  assign way_onehot   = (lru_way_i != '0) &&
                        ((lru_way_i & (lru_way_i - NUM_WAYS'(1))) == '0);

  always_comb begin
    err_cause               = '0;
    err_cause[ErrSpurious]  = lru_valid_i && !store_issued;
    err_cause[ErrMissing]   = store_issued && !lru_valid_i;
    err_cause[ErrNotOneHot] = lru_valid_i && !way_onehot;
  end

  assign rsp_fire = store_issued && lru_valid_i && way_onehot;

  always_comb begin
    lru_way_enc = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (lru_way_i[i]) begin
        lru_way_enc = WayW'(i);
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_fire ? (NUM_REQ'(1) << owner_q) : '0;
    rsp_way_d   = rsp_fire ? lru_way_enc : rsp_way_q;
    err_d       = err_q | (|err_cause);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      ls_valid_q  <= 1'b0;
      ls_op_q     <= OpNop;
      ls_way_q    <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_way_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      ls_valid_q  <= ls_valid_d;
      ls_op_q     <= ls_op_d;
      ls_way_q    <= ls_way_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
      err_q       <= err_d;
    end
  end

  assign ls_valid_o  = ls_valid_q;
  assign ls_op_o     = ls_op_q;
  assign ls_way_o    = ls_way_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_way_o   = rsp_way_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_lru_arbiter.sv
// Bench for lru_arbiter (NUM_REQ=4, NUM_WAYS=4): directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_lru_arbiter;

  localparam int NR = 4;
  localparam int NW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NR-1:0]       req_valid_i;
  logic [NR-1:0][1:0]  req_op_i;
  logic [NR-1:0][1:0]  req_way_i;
  logic [NR-1:0]       req_ready_o;
  logic                ls_valid_o;
  logic [1:0]          ls_op_o;
  logic [1:0]          ls_way_o;
  logic                lru_valid_i;
  logic [NW-1:0]       lru_way_i;
  logic [NR-1:0]       rsp_valid_o;
  logic [1:0]          rsp_way_o;
  logic                err_o;

  lru_arbiter #(
    .NUM_REQ  (NR),
    .NUM_WAYS (NW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_op_i    (req_op_i),
    .req_way_i   (req_way_i),
    .req_ready_o (req_ready_o),
    .ls_valid_o  (ls_valid_o),
    .ls_op_o     (ls_op_o),
    .ls_way_o    (ls_way_o),
    .lru_valid_i (lru_valid_i),
    .lru_way_i   (lru_way_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_way_o   (rsp_way_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the outputs must show in the current cycle
  int       m_ptr, m_gnt, m_ls_way, m_owner, m_rsp_owner, m_rsp_way;
  bit       m_ls_v, m_rsp_v, m_err;
  bit [1:0] m_ls_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Round-robin from the pointer; INVALIDATEs first when the priority feature is built in
  function automatic int pick();
    int best = -1;
    bit any_inv = 1'b0;
`ifdef LRU_ARB_INV_PRIO_EN
    for (int i = 0; i < NR; i++) if (req_valid_i[i] && req_op_i[i] == 2'b11) any_inv = 1'b1;
`endif
    for (int k = 0; k < NR; k++) begin
      int idx = (m_ptr + k) % NR;
      if (best < 0 && req_valid_i[idx] && (!any_inv || req_op_i[idx] == 2'b11)) best = idx;
    end
    return best;
  endfunction

  // One clock cycle: called just after a rising edge with inputs already driven
  task automatic step();
    bit store_now;
    int ones;
    m_gnt = pick();
    @(negedge clk);
    check("req_ready", req_ready_o, (m_gnt >= 0) ? (1 << m_gnt) : 0);
    check("ls_valid", ls_valid_o, m_ls_v);
    if (m_ls_v) begin
      check("ls_op", ls_op_o, m_ls_op);
      if (m_ls_op != 2'b10) check("ls_way", ls_way_o, m_ls_way);
    end
    check("rsp_valid", rsp_valid_o, m_rsp_v ? (1 << m_rsp_owner) : 0);
    if (m_rsp_v) check("rsp_way", rsp_way_o, m_rsp_way);
    check("err", err_o, m_err);
    @(posedge clk);
    store_now = m_ls_v && (m_ls_op == 2'b10);
    ones      = $countones(lru_way_i);
    if ((lru_valid_i && !store_now) || (store_now && !lru_valid_i) || (lru_valid_i && ones != 1))
      m_err = 1'b1;
    if (store_now && lru_valid_i && ones == 1) begin
      m_rsp_v     = 1'b1;
      m_rsp_owner = m_owner;
      m_rsp_way   = $clog2(lru_way_i);
    end else begin
      m_rsp_v = 1'b0;
    end
    m_ls_v = 1'b0;
    if (m_gnt >= 0) begin
      if (req_op_i[m_gnt] != 2'b00) begin
        m_ls_v   = 1'b1;
        m_ls_op  = req_op_i[m_gnt];
        m_ls_way = req_way_i[m_gnt];
        m_owner  = m_gnt;
      end
      m_ptr = (m_gnt + 1) % NR;
    end
    #1;
  endtask

  // Asserts reset mid-cycle (asynchronous) with requests pending, checks the reset state
  task automatic do_reset();
    reset       = 1'b1;
    lru_valid_i = 1'b0;
    req_valid_i = '1;
    for (int i = 0; i < NR; i++) req_op_i[i] = 2'b01;
    m_ptr = 0; m_ls_v = 0; m_rsp_v = 0; m_err = 0;
    #2;
    check("rst_ready", req_ready_o, 0);
    check("rst_ls_valid", ls_valid_o, 0);
    check("rst_ls_op", ls_op_o, 0);
    check("rst_ls_way", ls_way_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_way", rsp_way_o, 0);
    check("rst_err", err_o, 0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    req_valid_i = '0;
  endtask

  initial begin
    reset = 1'b1; req_valid_i = '0; req_op_i = '0; req_way_i = '0;
    lru_valid_i = 1'b0; lru_way_i = '0;
    @(posedge clk); #1;
    do_reset();

    // STORE from req0, allocation way 2
    req_valid_i = 4'b0001; req_op_i[0] = 2'b10; req_way_i[0] = 2'd0;
    #1 check("store_ready", req_ready_o, 4'b0001);
    step();
    req_valid_i = '0; lru_valid_i = 1'b1; lru_way_i = 4'b0100;
    check("store_ls_valid", ls_valid_o, 1);
    check("store_ls_op", ls_op_o, 2'b10);
    step();
    lru_valid_i = 1'b0;
    check("store_rsp_valid", rsp_valid_o, 4'b0001);
    check("store_rsp_way", rsp_way_o, 2);
    check("store_no_err", err_o, 0);
    step();

    // All requesters hold LOAD: strict rotation, no bubbles
    do_reset();
    req_valid_i = 4'hf;
    for (int i = 0; i < NR; i++) begin req_op_i[i] = 2'b01; req_way_i[i] = 2'(i); end
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_order", req_ready_o, 1 << (k % NR));
      if (k > 0) check("rr_ls_valid", ls_valid_o, 1);
      step();
    end
    req_valid_i = '0;
    check("rr_ls_way_last", ls_way_o, 3);
    step();

    // NOP consumed silently, then LOAD way 3
    do_reset();
    req_valid_i = 4'b0110; req_op_i[1] = 2'b00; req_op_i[2] = 2'b01; req_way_i[2] = 2'd3;
    #1 check("nop_ready", req_ready_o, 4'b0010);
    step();
    req_valid_i = 4'b0100;
    check("nop_ls_valid", ls_valid_o, 0);
    #1 check("load_ready", req_ready_o, 4'b0100);
    step();
    req_valid_i = '0;
    check("load_ls_valid", ls_valid_o, 1);
    check("load_ls_way", ls_way_o, 3);
    step();
    check("load_no_rsp", rsp_valid_o, 0);
    step();

    // STORE with no allocation: sticky error, no response
    do_reset();
    req_valid_i = 4'b0001; req_op_i[0] = 2'b10;
    step();
    req_valid_i = '0;
    step();
    check("miss_err", err_o, 1);
    check("miss_no_rsp", rsp_valid_o, 0);
    repeat (3) step();
    check("miss_err_sticky", err_o, 1);

    // req0 LOAD vs req3 INVALIDATE at pointer 0
    do_reset();
    req_valid_i = 4'b1001; req_op_i[0] = 2'b01; req_op_i[3] = 2'b11;
`ifdef LRU_ARB_INV_PRIO_EN
    #1 check("inv_prio", req_ready_o, 4'b1000);
`else
    #1 check("inv_prio", req_ready_o, 4'b0001);
`endif
    step();
    req_valid_i = '0;
    step();
    step();

    // Reset while a STORE is in flight
    do_reset();
    req_valid_i = 4'b0001; req_op_i[0] = 2'b10;
    step();
    lru_way_i = 4'b0001;
    do_reset();
    step();
    check("rst_flight_no_rsp", rsp_valid_o, 0);
    req_valid_i = 4'hf;
    for (int i = 0; i < NR; i++) req_op_i[i] = 2'b01;
    #1 check("rst_ptr_zero", req_ready_o, 4'b0001);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      req_valid_i = 4'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_op_i[i]  = 2'($urandom);
        req_way_i[i] = 2'($urandom);
      end
      if (m_ls_v && m_ls_op == 2'b10) begin
        lru_valid_i = 1'b1;
        lru_way_i   = 4'(1 << $urandom_range(0, NW - 1));
      end else begin
        lru_valid_i = 1'b0;
        lru_way_i   = 4'($urandom);
      end
      if ($urandom_range(0, 99) == 0) lru_valid_i = ~lru_valid_i;
      if ($urandom_range(0, 99) == 0) lru_way_i = 4'b0110;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
